acc_datapath_v2: RTL

Parametrised successor to the accumulator datapath of the 8-bit teaching processor. It contains the program counter, accumulator, status flags, a resettable register file, an 8-function ALU and a hardware return-address stack, supporting conditional branches and call/return. It sits between instruction memory (Pc out, MemData in) and the control FSM, which drives all select/enable lines. Every state update completes in one clock.

---
 rtl/acc_datapath_v2.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/acc_datapath_v2.sv
// Accumulator datapath: PC, accumulator, flags, register file, 8-function ALU
// and a return-address stack. Every state update completes in one clock.
module acc_datapath_v2 #(
    parameter int n           = 8,
    parameter int pc_n        = 5,
    parameter int regcount    = 11,
    parameter int stack_depth = 4,
    localparam int CW         = $clog2(stack_depth + 1)
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic [n-1:0]    MemData,
    input  logic [n-1:0]    Switches,
    input  logic            RegWe,
    input  logic            ImmSel,
    input  logic            WDataSel,
    input  logic            AccStore,
    input  logic            Op1Sel,
    input  logic            PcWe,
    input  logic            FlagWe,
    input  logic [2:0]      AluOp,
    input  logic [2:0]      PcSel,
    output logic [pc_n-1:0] Pc,
    output logic [n-1:0]    LEDs,
    output logic            Zero,
    output logic            Carry,
    output logic [CW-1:0]   StackCount,
    output logic            StackErr
);

    typedef enum logic [2:0] {
        PC_INC   = 3'b000,
        PC_JUMP  = 3'b001,
        PC_BZERO = 3'b010,
        PC_BCARY = 3'b011,
        PC_CALL  = 3'b100,
        PC_RET   = 3'b101
    } pc_sel_e;

    logic [pc_n-1:0] pc_q, pc_d, pc_inc, target, stack_top;
    logic [n-1:0]    acc_q, regs_q [regcount];
    logic [pc_n-1:0] stack_q [stack_depth];
    logic            zero_q, carry_q, err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;
    logic [3:0]      raddr;
    logic [n-1:0]    imm, rdata, alu_a, alu_r, wdata;
    logic            alu_c;
    logic            unused_mem;

    assign raddr      = MemData[3:0];
    assign unused_mem = ^MemData[n-1:4];
    assign imm        = ImmSel ? {MemData[3:0], {(n-4){1'b0}}} : {{(n-4){1'b0}}, MemData[3:0]};
    assign alu_a      = Op1Sel ? imm : rdata;
    assign wdata      = WDataSel ? Switches : acc_q;
    assign pc_inc     = pc_q + 1'b1;
    assign target     = alu_r[pc_n-1:0];

    // Indices at or above regcount match no entry, so they read as zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rdata = '0;
        for (int i = 0; i < regcount; i++)
            if (raddr == 4'(i)) rdata = regs_q[i];
    end

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < stack_depth; i++)
            if (cnt_q == CW'(i + 1)) stack_top = stack_q[i];
    end

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        case (AluOp)
            3'd0: alu_r = alu_a;
            3'd1: {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, acc_q};
            3'd2: begin
                alu_r = acc_q - alu_a;
                alu_c = alu_a > acc_q;
            end
            3'd3: alu_r = alu_a & acc_q;
            3'd4: alu_r = alu_a | acc_q;
            3'd5: alu_r = alu_a ^ acc_q;
            3'd6: begin
                alu_r = {acc_q[n-2:0], 1'b0};
                alu_c = acc_q[n-1];
            end
            default: begin
                alu_r = {1'b0, acc_q[n-1:1]};
                alu_c = acc_q[0];
            end
        endcase
    end

    // Branch conditions use the registered flags, i.e. the pre-edge values.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (PcWe) begin
            case (pc_sel_e'(PcSel))
                PC_JUMP:  pc_d = target;
                PC_BZERO: pc_d = zero_q  ? target : pc_inc;
                PC_BCARY: pc_d = carry_q ? target : pc_inc;
                PC_CALL: begin
                    if (cnt_q != CW'(stack_depth)) begin
                        push  = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        pc_d  = target;
                    end else begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end
                PC_RET: begin
                    if (cnt_q != '0) begin
                        pop   = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                        pc_d  = stack_top;
                    end else begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_q    <= '0;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (AccStore) acc_q <= alu_r;
            if (FlagWe) begin
                zero_q  <= (alu_r == '0);
                carry_q <= alu_c;
            end
        end
    end

    // NOTE: the register file must read zero after reset, so it is reset like any flop;
    // the stack is reset too so a stale entry can never leak out after reset.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < regcount; i++) regs_q[i] <= '0;
            for (int i = 0; i < stack_depth; i++) stack_q[i] <= '0;
        end else begin
            for (int i = 0; i < regcount; i++)
                if (RegWe && raddr == 4'(i)) regs_q[i] <= wdata;
            for (int i = 0; i < stack_depth; i++)
                if (push && cnt_q == CW'(i)) stack_q[i] <= pc_inc;
        end
    end

    assign Pc         = pc_q;
    assign LEDs       = acc_q;
    assign Zero       = zero_q;
    assign Carry      = carry_q;
    assign StackCount = cnt_q;
    assign StackErr   = err_q;

endmodule
